// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with occupancy count, almost
//            thresholds, synchronous flush and optional first-word-fall-through.
// Revision : 1.0
// ============================================================================
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter bit FWFT       = 1'b0,
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count
);

    localparam int c_AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    if (FIFO_WIDTH < 1) begin : g_chk_width
        $error("sync_fifo_param: FIFO_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 2) begin : g_chk_depth
        $error("sync_fifo_param: FIFO_DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_chk_af
        $error("sync_fifo_param: AF_THRESH out of range 1..FIFO_DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_chk_ae
        $error("sync_fifo_param: AE_THRESH out of range 0..FIFO_DEPTH-1");
    end

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [c_AW-1:0]       w_wr_ptr_nxt;
    logic [c_AW-1:0]       w_rd_ptr_nxt;

    // Flags decode from the count register only, so no path from wr_en/rd_en.
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_wr_acc    = wr_en && !w_full;
    assign w_rd_acc    = rd_en && !w_empty;

    assign w_wr_ptr_nxt = (r_wr_ptr == c_AW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_AW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    if (FWFT) begin : g_fwft
        assign data_out = r_mem[r_rd_ptr];
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] r_data_out;
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r_data_out <= '0;
            end else if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
        assign data_out = r_data_out;
    end

    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count >= CW'(AF_THRESH));
    assign almostempty = (r_count <= CW'(AE_THRESH));
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Directed self-checking bench for sync_fifo_param (standard + FWFT).
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_param;

    localparam int c_W  = 16;
    localparam int c_D  = 8;
    localparam int c_CW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           wr_en = 1'b0;
    logic           rd_en = 1'b0;
    logic [c_W-1:0] data_in = '0;
    logic [c_W-1:0] data_out;
    logic           wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
    logic [c_CW-1:0] count;

    logic           f_flush = 1'b0;
    logic           f_wr_en = 1'b0;
    logic           f_rd_en = 1'b0;
    logic [c_W-1:0] f_data_in = '0;
    logic [c_W-1:0] f_data_out;
    logic           f_wr_ack, f_overflow, f_underflow, f_full, f_empty, f_af, f_ae;
    logic [c_CW-1:0] f_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .FIFO_WIDTH(c_W), .FIFO_DEPTH(c_D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)
    ) u_std (
        .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en),
        .rd_en(rd_en), .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
        .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
        .almostempty(almostempty), .count(count)
    );

    sync_fifo_param #(
        .FIFO_WIDTH(c_W), .FIFO_DEPTH(c_D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)
    ) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .data_in(f_data_in), .wr_en(f_wr_en),
        .rd_en(f_rd_en), .data_out(f_data_out), .wr_ack(f_wr_ack), .overflow(f_overflow),
        .underflow(f_underflow), .full(f_full), .empty(f_empty), .almostfull(f_af),
        .almostempty(f_ae), .count(f_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) begin
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            data_in = 16'($urandom);
            f_wr_en = 1'($urandom_range(0, 1));
            f_rd_en = 1'($urandom_range(0, 1));
            tick();
        end
        n_total++; if (count !== 4'd0) $display("FAIL rst_count: got %0d exp 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b exp 1", empty); else n_pass++;
        n_total++; if (almostempty !== 1'b1) $display("FAIL rst_ae: got %b exp 1", almostempty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL rst_full: got %b exp 0", full); else n_pass++;
        n_total++; if (almostfull !== 1'b0) $display("FAIL rst_af: got %b exp 0", almostfull); else n_pass++;
        n_total++; if (data_out !== 16'h0) $display("FAIL rst_dout: got %h exp 0000", data_out); else n_pass++;
        n_total++; if ({wr_ack, overflow, underflow} !== 3'b000) $display("FAIL rst_flags: got %b exp 000", {wr_ack, overflow, underflow}); else n_pass++;
        n_total++; if ({f_count, f_empty, f_ae} !== 6'b0000_11) $display("FAIL rst_fwft: got %b exp 000011", {f_count, f_empty, f_ae}); else n_pass++;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_fill_overflow;
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; data_in = 16'(i);
            tick();
            n_total++; if (wr_ack !== 1'b1) $display("FAIL fill_ack[%0d]: got %b exp 1", i, wr_ack); else n_pass++;
            n_total++; if (count !== 4'(i)) $display("FAIL fill_count[%0d]: got %0d exp %0d", i, count, i); else n_pass++;
            n_total++; if (almostempty !== (i <= 2)) $display("FAIL fill_ae[%0d]: got %b exp %b", i, almostempty, (i <= 2)); else n_pass++;
            n_total++; if (almostfull !== (i >= 6)) $display("FAIL fill_af[%0d]: got %b exp %b", i, almostfull, (i >= 6)); else n_pass++;
            n_total++; if (full !== (i == 8)) $display("FAIL fill_full[%0d]: got %b exp %b", i, full, (i == 8)); else n_pass++;
        end
        data_in = 16'h0009;
        tick();
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", overflow); else n_pass++;
        n_total++; if (wr_ack !== 1'b0) $display("FAIL ovf_ack: got %b exp 0", wr_ack); else n_pass++;
        n_total++; if (count !== 4'd8) $display("FAIL ovf_count: got %0d exp 8", count); else n_pass++;
        wr_en = 1'b0;
        tick();
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_pulse: got %b exp 0", overflow); else n_pass++;
        n_total++; if (data_out !== 16'h0000) $display("FAIL fill_dout_hold: got %h exp 0000", data_out); else n_pass++;
    endtask

    task automatic test_drain_underflow;
        rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_total++; if (data_out !== 16'(i)) $display("FAIL drain_dout[%0d]: got %h exp %h", i, data_out, 16'(i)); else n_pass++;
            n_total++; if (count !== 4'(8 - i)) $display("FAIL drain_count[%0d]: got %0d exp %0d", i, count, 8 - i); else n_pass++;
        end
        tick();
        n_total++; if (underflow !== 1'b1) $display("FAIL udf_flag: got %b exp 1", underflow); else n_pass++;
        n_total++; if (data_out !== 16'h0008) $display("FAIL udf_dout: got %h exp 0008", data_out); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL udf_empty: got %b exp 1", empty); else n_pass++;
        rd_en = 1'b0;
        tick();
        n_total++; if (underflow !== 1'b0) $display("FAIL udf_pulse: got %b exp 0", underflow); else n_pass++;
    endtask

    task automatic test_back_to_back;
        wr_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_in = 16'(16'h0100 + k);
            tick();
        end
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data_in = 16'(16'h0104 + k);
            tick();
            n_total++; if (data_out !== 16'(16'h0100 + k)) $display("FAIL b2b_dout[%0d]: got %h exp %h", k, data_out, 16'(16'h0100 + k)); else n_pass++;
            n_total++; if (count !== 4'd4) $display("FAIL b2b_count[%0d]: got %0d exp 4", k, count); else n_pass++;
        end
        rd_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data_in = 16'(16'h0118 + k);
            tick();
        end
        n_total++; if (full !== 1'b1) $display("FAIL b2b_full: got %b exp 1", full); else n_pass++;
        // Full: the read goes through, the write bounces.
        rd_en = 1'b1; data_in = 16'h01FF;
        tick();
        n_total++; if (count !== 4'd7) $display("FAIL fullrw_count: got %0d exp 7", count); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL fullrw_ovf: got %b exp 1", overflow); else n_pass++;
        n_total++; if (wr_ack !== 1'b0) $display("FAIL fullrw_ack: got %b exp 0", wr_ack); else n_pass++;
        n_total++; if (data_out !== 16'h0114) $display("FAIL fullrw_dout: got %h exp 0114", data_out); else n_pass++;
        wr_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            n_total++; if (data_out !== 16'(16'h0115 + k)) $display("FAIL rest_dout[%0d]: got %h exp %h", k, data_out, 16'(16'h0115 + k)); else n_pass++;
        end
        // Empty: the write goes through, the read bounces.
        wr_en = 1'b1; data_in = 16'h0155;
        tick();
        n_total++; if (count !== 4'd1) $display("FAIL emptyrw_count: got %0d exp 1", count); else n_pass++;
        n_total++; if ({wr_ack, underflow} !== 2'b11) $display("FAIL emptyrw_flags: got %b exp 11", {wr_ack, underflow}); else n_pass++;
        n_total++; if (data_out !== 16'h011B) $display("FAIL emptyrw_dout: got %h exp 011b", data_out); else n_pass++;
        wr_en = 1'b0;
        tick();
        n_total++; if (data_out !== 16'h0155) $display("FAIL emptyrw_read: got %h exp 0155", data_out); else n_pass++;
        n_total++; if (count !== 4'd0) $display("FAIL emptyrw_end: got %0d exp 0", count); else n_pass++;
        rd_en = 1'b0;
    endtask

    task automatic test_flush;
        wr_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data_in = 16'(16'h0200 + k);
            tick();
        end
        n_total++; if (count !== 4'd5) $display("FAIL flush_pre: got %0d exp 5", count); else n_pass++;
        flush = 1'b1; rd_en = 1'b1; data_in = 16'h02FF;
        tick();
        flush = 1'b0; rd_en = 1'b0;
        n_total++; if (count !== 4'd0) $display("FAIL flush_count: got %0d exp 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL flush_empty: got %b exp 1", empty); else n_pass++;
        n_total++; if ({wr_ack, overflow, underflow} !== 3'b000) $display("FAIL flush_flags: got %b exp 000", {wr_ack, overflow, underflow}); else n_pass++;
        n_total++; if (data_out !== 16'h0000) $display("FAIL flush_dout: got %h exp 0000", data_out); else n_pass++;
        data_in = 16'h0300;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_total++; if (data_out !== 16'h0300) $display("FAIL flush_new: got %h exp 0300", data_out); else n_pass++;
        n_total++; if (count !== 4'd0) $display("FAIL flush_newcnt: got %0d exp 0", count); else n_pass++;
    endtask

    task automatic test_reset_mid;
        wr_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            data_in = 16'(16'h0400 + k);
            tick();
        end
        rst = 1'b1; rd_en = 1'b1;
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        n_total++; if (count !== 4'd0) $display("FAIL rstmid_count: got %0d exp 0", count); else n_pass++;
        n_total++; if ({empty, full} !== 2'b10) $display("FAIL rstmid_ef: got %b exp 10", {empty, full}); else n_pass++;
        n_total++; if ({wr_ack, overflow, underflow} !== 3'b000) $display("FAIL rstmid_flags: got %b exp 000", {wr_ack, overflow, underflow}); else n_pass++;
        n_total++; if (data_out !== 16'h0000) $display("FAIL rstmid_dout: got %h exp 0000", data_out); else n_pass++;
    endtask

    task automatic test_fwft;
        f_wr_en = 1'b1; f_data_in = 16'hAAAA;
        tick();
        f_wr_en = 1'b0;
        n_total++; if (f_data_out !== 16'hAAAA) $display("FAIL fwft_first: got %h exp aaaa", f_data_out); else n_pass++;
        n_total++; if ({f_empty, f_wr_ack, f_count} !== 6'b01_0001) $display("FAIL fwft_state1: got %b exp 010001", {f_empty, f_wr_ack, f_count}); else n_pass++;
        f_wr_en = 1'b1; f_data_in = 16'hBBBB;
        tick();
        f_wr_en = 1'b0;
        n_total++; if (f_data_out !== 16'hAAAA) $display("FAIL fwft_head: got %h exp aaaa", f_data_out); else n_pass++;
        f_rd_en = 1'b1;
        tick();
        n_total++; if (f_data_out !== 16'hBBBB) $display("FAIL fwft_next: got %h exp bbbb", f_data_out); else n_pass++;
        n_total++; if (f_count !== 4'd1) $display("FAIL fwft_count: got %0d exp 1", f_count); else n_pass++;
        tick();
        n_total++; if ({f_empty, f_ae, f_af, f_full} !== 4'b1100) $display("FAIL fwft_empty: got %b exp 1100", {f_empty, f_ae, f_af, f_full}); else n_pass++;
        tick();
        f_rd_en = 1'b0;
        n_total++; if ({f_underflow, f_overflow} !== 2'b10) $display("FAIL fwft_udf: got %b exp 10", {f_underflow, f_overflow}); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_fwft();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
